coeff_buffer: RTL

- Coefficient store that answers the approximation-engine controller's coefficient handshake.
- Accepts polynomial coefficients lowest-degree first while the controller grants writes.
- Raises start_coeff when the set is complete and reports the highest-degree index on wr_ptr_coeff.
- Plays coefficients back highest-degree first, one per rd_en_coeff, for Horner evaluation; redo_coeff rewinds playback to the top.

---
 rtl/coeff_buffer_if.sv | 31 +++
 rtl/coeff_buffer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/coeff_buffer_if.sv
// rtl/coeff_buffer_if.sv - coefficient handshake bundle between approximation controller and coeff_buffer
interface coeff_buffer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_LINES = 4
);
  // controller -> buffer
  logic                  wr_en_coeff;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  clear;
  logic                  rd_en_coeff;
  logic                  redo_coeff;
  // buffer -> controller
  logic                  start_coeff;
  logic [ADDR_LINES-1:0] wr_ptr_coeff;
  logic [DATA_WIDTH-1:0] coeff_out;
  logic                  coeff_valid;
  logic                  overflow;
  logic                  underrun;

  modport master (
    output wr_en_coeff, in_valid, in_data, in_last, clear, rd_en_coeff, redo_coeff,
    input  start_coeff, wr_ptr_coeff, coeff_out, coeff_valid, overflow, underrun
  );

  modport slave (
    input  wr_en_coeff, in_valid, in_data, in_last, clear, rd_en_coeff, redo_coeff,
    output start_coeff, wr_ptr_coeff, coeff_out, coeff_valid, overflow, underrun
  );
endinterface

// File: rtl/coeff_buffer.sv
// rtl/coeff_buffer.sv - polynomial coefficient store: ascending load, descending Horner playback
module coeff_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_LINES = 4
) (
  input  logic           clk,
  input  logic           rst,
  coeff_buffer_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_LINES;
  localparam logic [ADDR_LINES-1:0] LAST_IDX = ADDR_LINES'(DEPTH - 1);

  typedef enum logic {
    LOAD  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_LINES-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_LINES-1:0] rd_ptr_q, rd_ptr_d;
  logic                  exhausted_q, exhausted_d;
  logic [ADDR_LINES-1:0] wr_ptr_coeff_q, wr_ptr_coeff_d;
  logic [DATA_WIDTH-1:0] coeff_out_q, coeff_out_d;
  logic                  coeff_valid_q, coeff_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underrun_q, underrun_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  mem_we;
  logic                  accept;

  assign accept = bus.wr_en_coeff & bus.in_valid;

  // next-state and datapath: clear dominates, then load or playback per state
  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    exhausted_d    = exhausted_q;
    wr_ptr_coeff_d = wr_ptr_coeff_q;
    coeff_out_d    = coeff_out_q;
    coeff_valid_d  = 1'b0;
    overflow_d     = overflow_q;
    underrun_d     = underrun_q;
    mem_we         = 1'b0;

    if (bus.clear) begin
      // discard the set (full or partial) and the sticky error flags
      state_d        = LOAD;
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      exhausted_d    = 1'b0;
      wr_ptr_coeff_d = '0;
      overflow_d     = 1'b0;
      underrun_d     = 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (accept) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            // set closes on an explicit last word or when the array is full
            if (bus.in_last || (wr_ptr_q == LAST_IDX)) begin
              state_d        = READY;
              wr_ptr_coeff_d = wr_ptr_q;
              rd_ptr_d       = wr_ptr_q;
              exhausted_d    = 1'b0;
            end
          end
        end

        READY: begin
          if (accept) begin
            overflow_d = 1'b1;
          end
          if (bus.redo_coeff) begin
            // rewind wins over a same-cycle pop; the pop is dropped
            rd_ptr_d    = wr_ptr_coeff_q;
            exhausted_d = 1'b0;
          end else if (bus.rd_en_coeff) begin
            if (exhausted_q) begin
              underrun_d = 1'b1;
            end else begin
              coeff_out_d   = mem_q[rd_ptr_q];
              coeff_valid_d = 1'b1;
              // pointer parks at 0 rather than wrapping to the top
              if (rd_ptr_q == '0) begin
                exhausted_d = 1'b1;
              end else begin
                rd_ptr_d = rd_ptr_q - 1'b1;
              end
            end
          end
        end

        default: begin
          state_d = LOAD;
        end
      endcase
    end
  end

  // control and output registers, asynchronously reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= LOAD;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      exhausted_q    <= 1'b0;
      wr_ptr_coeff_q <= '0;
      coeff_out_q    <= '0;
      coeff_valid_q  <= 1'b0;
      overflow_q     <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      exhausted_q    <= exhausted_d;
      wr_ptr_coeff_q <= wr_ptr_coeff_d;
      coeff_out_q    <= coeff_out_d;
      coeff_valid_q  <= coeff_valid_d;
      overflow_q     <= overflow_d;
      underrun_q     <= underrun_d;
    end
  end

  // coefficient array write port; contents need no reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  assign bus.start_coeff  = (state_q == READY);
  assign bus.wr_ptr_coeff = wr_ptr_coeff_q;
  assign bus.coeff_out    = coeff_out_q;
  assign bus.coeff_valid  = coeff_valid_q;
  assign bus.overflow     = overflow_q;
  assign bus.underrun     = underrun_q;

endmodule
